// File: rtl/audio_mixer_n_pkg.sv
// ============================================================================
// audio_mix_pkg : opcodes, FSM state type and clog2 helper for audio_mixer_n
// Revision: 1.0
// ============================================================================
`default_nettype none

package audio_mix_pkg;

  localparam logic [7:0] OP_NOP      = 8'd0;
  localparam logic [7:0] OP_SELECT   = 8'd1;
  localparam logic [7:0] OP_CH_VOL   = 8'd2;
  localparam logic [7:0] OP_CH_EN    = 8'd3;
  localparam logic [7:0] OP_MASTER   = 8'd4;
  localparam logic [7:0] OP_CLR_CLIP = 8'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/audio_mixer_n_if.sv
// ============================================================================
// audio_mixer_n_if : command, sample and mixed-output signals of the mixer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface audio_mixer_n_if #(
  parameter int N_CH = 4,
  parameter int W    = 16
);
  logic              cmd_valid;
  logic [23:0]       cmd;
  logic [N_CH*W-1:0] ch_sample;
  logic [N_CH-1:0]   ch_valid;
  logic [W-1:0]      out_sample;
  logic              out_valid;
  logic              clip;
  logic              busy;

  modport master (
    output cmd_valid, cmd, ch_sample, ch_valid,
    input  out_sample, out_valid, clip, busy
  );

  modport slave (
    input  cmd_valid, cmd, ch_sample, ch_valid,
    output out_sample, out_valid, clip, busy
  );
endinterface

`default_nettype wire

// File: rtl/audio_mixer_n_cfg_regs.sv
// ============================================================================
// mix_cfg_regs : command decode and per-channel volume/enable, select, master
// Revision: 1.0
// ============================================================================
`default_nettype none

module mix_cfg_regs
  import audio_mix_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [23:0]       cmd,
  output logic [3*N_CH-1:0] vol,
  output logic [N_CH-1:0]   en,
  output logic [2:0]        master_shift,
  output logic              clr_clip
);

  logic [CH_W-1:0]   select_q, select_d;
  logic [3*N_CH-1:0] vol_q, vol_d;
  logic [N_CH-1:0]   en_q, en_d;
  logic [2:0]        master_q, master_d;
  logic [7:0]        opcode;
  logic              sel_ok;
  int                sel_i;
  logic              unused_payload;

  assign opcode         = cmd[23:16];
  assign sel_i          = int'(select_q);
  assign sel_ok         = (sel_i < N_CH);
  assign unused_payload = ^cmd[15:0];

  always_comb begin
    select_d = select_q;
    vol_d    = vol_q;
    en_d     = en_q;
    master_d = master_q;
    if (cmd_valid) begin
      case (opcode)
        OP_SELECT: select_d = cmd[CH_W-1:0];
        // Out-of-range select makes per-channel writes no-ops
        OP_CH_VOL: if (sel_ok) vol_d[sel_i*3 +: 3] = cmd[2:0];
        OP_CH_EN:  if (sel_ok) en_d[sel_i +: 1]    = cmd[0];
        OP_MASTER: master_d = cmd[2:0];
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      select_q <= '0;
      vol_q    <= {N_CH{3'd7}};
      en_q     <= '1;
      master_q <= 3'd0;
    end else begin
      select_q <= select_d;
      vol_q    <= vol_d;
      en_q     <= en_d;
      master_q <= master_d;
    end
  end

  assign vol          = vol_q;
  assign en           = en_q;
  assign master_shift = master_q;
  assign clr_clip     = cmd_valid && (opcode == OP_CLR_CLIP);

endmodule

`default_nettype wire

// File: rtl/audio_mixer_n.sv
// ============================================================================
// audio_mixer_n : N-channel sequential mixer with volume, enable, master shift
// Revision: 1.0
// ============================================================================
`default_nettype none

module audio_mixer_n
  import audio_mix_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 16,
  parameter int CH_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  audio_mixer_n_if.slave  bus
);

  localparam int              AW       = W + clog2(N_CH) + 1;
  localparam logic [AW-1:0]   SAT_MAX  = {{(AW-W){1'b0}}, {W{1'b1}}};
  localparam logic [CH_W-1:0] IDX_ONE  = CH_W'(1);
  localparam logic [CH_W-1:0] LAST_IDX = CH_W'(N_CH - 1);

  logic [3*N_CH-1:0] cfg_vol;
  logic [N_CH-1:0]   cfg_en;
  logic [2:0]        cfg_master;
  logic              clr_clip;

  mix_cfg_regs #(.N_CH(N_CH), .CH_W(CH_W)) u_cfg (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (bus.cmd_valid),
    .cmd          (bus.cmd),
    .vol          (cfg_vol),
    .en           (cfg_en),
    .master_shift (cfg_master),
    .clr_clip     (clr_clip)
  );

  state_t            state_q, state_d;
  logic [N_CH*W-1:0] lat_q, lat_d, snap_q, snap_d;
  logic [3*N_CH-1:0] snap_vol_q, snap_vol_d;
  logic [N_CH-1:0]   snap_en_q, snap_en_d;
  logic [2:0]        snap_master_q, snap_master_d;
  logic              pending_q, pending_d;
  logic [CH_W-1:0]   idx_q, idx_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [W-1:0]      out_sample_q, out_sample_d;
  logic              out_valid_q, out_valid_d;
  logic              clip_q, clip_d;

  int                idx_i;
  logic [W-1:0]      cur_samp;
  logic [2:0]        cur_vol;
  logic              cur_en;
  logic [W+2:0]      gain;
  logic [W+2:0]      prod;
  logic [W-1:0]      term;
  logic              overflow;
  logic [W-1:0]      sat;
  logic              any_valid;

  always_comb begin
    lat_d = lat_q;
    for (int k = 0; k < N_CH; k++) begin
      if (bus.ch_valid[k]) lat_d[k*W +: W] = bus.ch_sample[k*W +: W];
    end
  end

  // Gain is (vol+1)/8, so the product never exceeds W+3 bits and the term fits W
  assign idx_i     = int'(idx_q);
  assign cur_samp  = snap_q[idx_i*W +: W];
  assign cur_vol   = snap_vol_q[idx_i*3 +: 3];
  assign cur_en    = snap_en_q[idx_i +: 1] == 1'b1;
  assign gain      = {{(W-1){1'b0}}, {1'b0, cur_vol} + 4'd1};
  assign prod      = {3'b000, cur_samp} * gain;
  assign term      = cur_en ? prod[W+2:3] : '0;
  assign overflow  = (acc_q > SAT_MAX);
  assign sat       = overflow ? {W{1'b1}} : acc_q[W-1:0];
  assign any_valid = |bus.ch_valid;

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q | any_valid;
    snap_d        = snap_q;
    snap_vol_d    = snap_vol_q;
    snap_en_d     = snap_en_q;
    snap_master_d = snap_master_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    out_sample_d  = out_sample_q;
    out_valid_d   = 1'b0;
    clip_d        = clip_q & ~clr_clip;
    case (state_q)
      IDLE: begin
        // A strobe in the snapshot cycle is folded into this mix, not left pending
        if (pending_q || any_valid) begin
          state_d       = ACCUM;
          snap_d        = lat_d;
          snap_vol_d    = cfg_vol;
          snap_en_d     = cfg_en;
          snap_master_d = cfg_master;
          pending_d     = 1'b0;
          acc_d         = '0;
          idx_d         = '0;
        end
      end
      ACCUM: begin
        acc_d = acc_q + {{(AW-W){1'b0}}, term};
        if (idx_q == LAST_IDX) state_d = OUT;
        else                   idx_d   = idx_q + IDX_ONE;
      end
      OUT: begin
        out_sample_d = sat >> snap_master_q;
        out_valid_d  = 1'b1;
        if (overflow) clip_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      lat_q         <= '0;
      snap_q        <= '0;
      snap_vol_q    <= '0;
      snap_en_q     <= '0;
      snap_master_q <= 3'd0;
      pending_q     <= 1'b0;
      idx_q         <= '0;
      acc_q         <= '0;
      out_sample_q  <= '0;
      out_valid_q   <= 1'b0;
      clip_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lat_q         <= lat_d;
      snap_q        <= snap_d;
      snap_vol_q    <= snap_vol_d;
      snap_en_q     <= snap_en_d;
      snap_master_q <= snap_master_d;
      pending_q     <= pending_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      out_sample_q  <= out_sample_d;
      out_valid_q   <= out_valid_d;
      clip_q        <= clip_d;
    end
  end

  assign bus.out_sample = out_sample_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.clip       = clip_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_audio_mixer_n.sv
// ============================================================================
// tb_audio_mixer_n : directed bench with a queue-based mix model for audio_mixer_n
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_audio_mixer_n;

  localparam int N_CH = 4;
  localparam int W    = 16;
  localparam int CH_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  audio_mixer_n_if #(.N_CH(N_CH), .W(W)) bus();

  audio_mixer_n #(.N_CH(N_CH), .W(W), .CH_W(CH_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_pulses = 0;

  int m_lat[N_CH];
  int m_vol[N_CH];
  int m_en[N_CH];
  int m_sel;
  int m_master;
  int m_clip;
  int exp_sample_q[$];
  int exp_clip_q[$];
  int last_sample;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_CH; k++) begin
      m_lat[k] = 0;
      m_vol[k] = 7;
      m_en[k]  = 1;
    end
    m_sel = 0;
    m_master = 0;
    m_clip = 0;
    last_sample = 0;
    exp_sample_q.delete();
    exp_clip_q.delete();
  endtask

  // Whole-mix result from the current model state: gain (vol+1)/8, saturate, shift
  task automatic push_mix();
    int sum;
    sum = 0;
    for (int k = 0; k < N_CH; k++)
      if (m_en[k] != 0) sum += (m_lat[k] * (m_vol[k] + 1)) / 8;
    if (sum > 65535) begin
      m_clip = 1;
      sum = 65535;
    end
    exp_sample_q.push_back(sum >> m_master);
    exp_clip_q.push_back(m_clip);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) begin
        n_pulses++;
        chk("pulse_expected", int'(exp_sample_q.size() > 0), 1);
        if (exp_sample_q.size() > 0) begin
          last_sample = exp_sample_q.pop_front();
          chk("out_sample", int'(bus.out_sample), last_sample);
          chk("clip_at_pulse", int'(bus.clip), exp_clip_q.pop_front());
        end
      end else begin
        chk("hold", int'(bus.out_sample), last_sample);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int op, input int pl);
    bus.cmd_valid = 1'b1;
    bus.cmd = {op[7:0], pl[15:0]};
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd = '0;
    case (op)
      1: m_sel = pl & 15;
      2: if (m_sel < N_CH) m_vol[m_sel] = pl & 7;
      3: if (m_sel < N_CH) m_en[m_sel] = pl & 1;
      4: m_master = pl & 7;
      5: m_clip = 0;
      default: ;
    endcase
  endtask

  // Drives the strobe for one edge and mirrors it into the model latches
  task automatic strobe(input logic [3:0] mask, input int s0, input int s1,
                        input int s2, input int s3);
    int s[N_CH];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int k = 0; k < N_CH; k++) begin
      bus.ch_sample[k*W +: W] = s[k][15:0];
      if (mask[k]) m_lat[k] = s[k] & 16'hFFFF;
    end
    bus.ch_valid = mask;
    tick();
    bus.ch_valid = '0;
  endtask

  task automatic wait_done();
    int done;
    done = 0;
    for (int i = 0; i < 100 && done == 0; i++) begin
      tick();
      if (exp_sample_q.size() == 0 && !bus.busy && !bus.out_valid) done = 1;
    end
    chk("wait_done", done, 1);
  endtask

  task automatic mix(input logic [3:0] mask, input int s0, input int s1,
                     input int s2, input int s3);
    strobe(mask, s0, s1, s2, s3);
    push_mix();
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int lat_k;
    int p0;
    bus.cmd_valid = 1'b0;
    bus.cmd       = '0;
    bus.ch_sample = '0;
    bus.ch_valid  = '0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("reset_out_sample", int'(bus.out_sample), 0);
    chk("reset_out_valid",  int'(bus.out_valid), 0);
    chk("reset_clip",       int'(bus.clip), 0);
    chk("reset_busy",       int'(bus.busy), 0);

    // 1: single channel latency and unity gain
    bus.ch_sample = '0;
    bus.ch_sample[15:0] = 16'h1000;
    bus.ch_valid = 4'b0001;
    m_lat[0] = 'h1000;
    push_mix();
    lat_k = 0;
    for (int k = 1; k <= 20 && lat_k == 0; k++) begin
      tick();
      if (k == 1) bus.ch_valid = '0;
      if (bus.out_valid) lat_k = k;
    end
    chk("t1_latency", lat_k, 6);
    wait_done();
    chk("t1_out", int'(bus.out_sample), 'h1000);
    chk("t1_clip", int'(bus.clip), 0);

    // 2: saturation, sticky clip, clear
    mix(4'hF, 'h6000, 'h6000, 'h6000, 'h6000);
    chk("t2_out", int'(bus.out_sample), 'hFFFF);
    chk("t2_clip", int'(bus.clip), 1);
    mix(4'hF, 0, 0, 0, 0);
    chk("t2_zero_out", int'(bus.out_sample), 0);
    chk("t2_clip_sticky", int'(bus.clip), 1);
    send_cmd(5, 0);
    chk("t2_clip_cleared", int'(bus.clip), 0);

    // 3: per-channel volume and enable
    send_cmd(1, 1);
    send_cmd(2, 3);
    mix(4'hF, 0, 'h8000, 0, 0);
    chk("t3_vol3", int'(bus.out_sample), 'h4000);
    send_cmd(3, 0);
    mix(4'hF, 0, 'h8000, 0, 0);
    chk("t3_disabled", int'(bus.out_sample), 0);
    send_cmd(3, 1);
    send_cmd(2, 7);

    // 4: master attenuation, out-of-range select ignored
    send_cmd(4, 2);
    mix(4'hF, 'hFFFF, 0, 0, 0);
    chk("t4_master", int'(bus.out_sample), 'h3FFF);
    send_cmd(1, 9);
    send_cmd(2, 0);
    mix(4'hF, 'hFFFF, 0, 0, 0);
    chk("t4_bad_select", int'(bus.out_sample), 'h3FFF);
    chk("t4_no_clip", int'(bus.clip), 0);
    send_cmd(4, 0);
    send_cmd(1, 0);

    // 5: strobes during ACCUM coalesce into exactly one follow-up mix
    p0 = n_pulses;
    bus.ch_sample = '0;
    bus.ch_sample[2*W +: W] = 16'h1000;
    bus.ch_valid = 4'hF;
    for (int k = 0; k < N_CH; k++) m_lat[k] = 0;
    m_lat[2] = 'h1000;
    tick();
    push_mix();
    bus.ch_valid = '0;
    tick();
    bus.ch_valid = 4'b0100;
    bus.ch_sample[2*W +: W] = 16'h2000;
    tick();
    bus.ch_sample[2*W +: W] = 16'h3000;
    m_lat[2] = 'h3000;
    tick();
    bus.ch_valid = '0;
    push_mix();
    wait_done();
    repeat (10) tick();
    chk("t5_pulses", n_pulses - p0, 2);
    chk("t5_out", int'(bus.out_sample), 'h3000);

    // 6: reset mid-ACCUM aborts the mix
    strobe(4'b0001, 'h1234, 0, 0, 0);
    tick();
    rst = 1'b1;
    model_reset();
    p0 = n_pulses;
    tick();
    chk("t6_out_valid", int'(bus.out_valid), 0);
    chk("t6_out_sample", int'(bus.out_sample), 0);
    chk("t6_busy", int'(bus.busy), 0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("t6_no_pulse", n_pulses - p0, 0);
    mix(4'b1000, 0, 0, 0, 'h0800);
    chk("t6_fresh_mix", int'(bus.out_sample), 'h0800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
